// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: MIPS field encodings and forward-select codes shared by the execute stage.
package ex_stage_pkg;
  localparam logic [5:0] OP_R = 6'h00, OP_JAL = 6'h03, OP_ORI = 6'h0d, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_SLL = 6'h00, FN_JALR = 6'h09, FN_MFHI = 6'h10, FN_MTHI = 6'h11;
  localparam logic [5:0] FN_MFLO = 6'h12, FN_MTLO = 6'h13, FN_MULT = 6'h18, FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV = 6'h1a, FN_DIVU = 6'h1b, FN_ADDU = 6'h21, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2a, FN_SLTU = 6'h2b;
  typedef enum logic [2:0] {FW_RF = 3'd0, FW_AOM = 3'd1, FW_WD = 3'd2} fwd_e;
  function automatic logic is_md_op(input logic [5:0] fn);
    return fn == FN_MULT || fn == FN_MULTU || fn == FN_DIV || fn == FN_DIVU;
  endfunction
endpackage

// File: rtl/ex_stage_md_unit.sv
// ex_stage_md_unit: multi-cycle mult/div with busy counter and HI/LO registers.
module ex_stage_md_unit
  import ex_stage_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rtype,
  input  logic [5:0]  i_funct,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy
);
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic [63:0] w_prod;
  logic signed [31:0] w_qs, w_rs;
  logic [31:0] w_q, w_r;
  logic w_start;
  assign o_busy  = r_cnt != '0;
  assign w_start = i_rtype & is_md_op(i_funct) & ~o_busy;
  assign o_hi = r_hi;
  assign o_lo = r_lo;
  // r_op[0] = unsigned variant, r_op[1] = divide
  assign w_prod = r_op[0] ? {32'b0, r_a} * {32'b0, r_b}
                          : {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_qs = $signed(r_a) / $signed(r_b);
  assign w_rs = $signed(r_a) % $signed(r_b);
  assign w_q  = r_op[0] ? r_a / r_b : w_qs;
  assign w_r  = r_op[0] ? r_a % r_b : w_rs;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (w_start) begin
      r_cnt <= i_funct[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      r_op  <= i_funct[1:0];
      r_a   <= i_rs;
      r_b   <= i_rt;
    end else if (o_busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        if (!r_op[1]) {r_hi, r_lo} <= w_prod;
        else if (r_b != '0) begin
          r_hi <= w_r;
          r_lo <= w_q;
        end
      end
    end else if (i_rtype && i_funct == FN_MTHI) r_hi <= i_rs;
    else if (i_rtype && i_funct == FN_MTLO) r_lo <= i_rs;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage -- forwarding, ALU, mult/div unit and E/M pipeline register.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IRE,
  input  logic [31:0] PC4E,
  input  logic [31:0] RSE,
  input  logic [31:0] RTE,
  input  logic [31:0] EXTE,
  input  logic [2:0]  Forward_RS_E_Sel,
  input  logic [2:0]  Forward_RT_E_Sel,
  input  logic [31:0] MUX_RF_WD_OUT,
  output logic [31:0] IRM,
  output logic [31:0] PC4M,
  output logic [31:0] AOM,
  output logic [31:0] RTM,
  output logic        MdStall
);
  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_sa;
  logic [31:0] w_rs, w_rt, w_alu, w_hi, w_lo;
  logic w_rtype, w_md_class, w_busy;
  assign w_op = IRE[31:26];
  assign w_fn = IRE[5:0];
  assign w_sa = IRE[10:6];
  assign w_rtype = w_op == OP_R;
  assign w_rs = Forward_RS_E_Sel == FW_AOM ? AOM : Forward_RS_E_Sel == FW_WD ? MUX_RF_WD_OUT : RSE;
  assign w_rt = Forward_RT_E_Sel == FW_AOM ? AOM : Forward_RT_E_Sel == FW_WD ? MUX_RF_WD_OUT : RTE;
  assign w_md_class = w_rtype & (is_md_op(w_fn) | w_fn == FN_MFHI | w_fn == FN_MFLO |
                                 w_fn == FN_MTHI | w_fn == FN_MTLO);
  // a starting op sees busy=0, so only a second md instruction stalls
  assign MdStall = w_md_class & w_busy;
  ex_stage_md_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) u_md (
    .clk(Clk), .rst_n(Reset), .i_rtype(w_rtype), .i_funct(w_fn), .i_rs(w_rs), .i_rt(w_rt),
    .o_hi(w_hi), .o_lo(w_lo), .o_busy(w_busy)
  );
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_R:
        case (w_fn)
          FN_ADDU: w_alu = w_rs + w_rt;
          FN_SUBU: w_alu = w_rs - w_rt;
          FN_AND:  w_alu = w_rs & w_rt;
          FN_OR:   w_alu = w_rs | w_rt;
          FN_SLT:  w_alu = {31'b0, $signed(w_rs) < $signed(w_rt)};
          FN_SLTU: w_alu = {31'b0, w_rs < w_rt};
          FN_SLL:  w_alu = w_rt << w_sa;
          FN_JALR: w_alu = PC4E + 32'd4;
          FN_MFHI: w_alu = w_hi;
          FN_MFLO: w_alu = w_lo;
          default: w_alu = '0;
        endcase
      OP_ORI:       w_alu = w_rs | EXTE;
      OP_LUI:       w_alu = EXTE << 16;
      OP_LW, OP_SW: w_alu = w_rs + EXTE;
      OP_JAL:       w_alu = PC4E + 32'd4;
      default:      w_alu = '0;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      IRM  <= '0;
      PC4M <= '0;
      AOM  <= '0;
      RTM  <= '0;
    end else begin
      IRM  <= MdStall ? '0 : IRE;
      PC4M <= MdStall ? '0 : PC4E;
      AOM  <= MdStall ? '0 : w_alu;
      RTM  <= MdStall ? '0 : w_rt;
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors for the execute stage with hand-computed expectations.
module tb_ex_stage;
  import ex_stage_pkg::*;
  logic Clk, Reset, MdStall;
  logic [31:0] IRE, PC4E, RSE, RTE, EXTE, MUX_RF_WD_OUT, IRM, PC4M, AOM, RTM;
  logic [2:0] Forward_RS_E_Sel, Forward_RT_E_Sel;
  int tests = 0, fails = 0, n;

  ex_stage dut (
    .Clk(Clk), .Reset(Reset), .IRE(IRE), .PC4E(PC4E), .RSE(RSE), .RTE(RTE), .EXTE(EXTE),
    .Forward_RS_E_Sel(Forward_RS_E_Sel), .Forward_RT_E_Sel(Forward_RT_E_Sel),
    .MUX_RF_WD_OUT(MUX_RF_WD_OUT), .IRM(IRM), .PC4M(PC4M), .AOM(AOM), .RTM(RTM),
    .MdStall(MdStall)
  );

  initial Clk = 0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] rt_ins(input logic [5:0] fn, input logic [4:0] sa = 5'd0);
    return {6'h00, 15'h0, sa, fn};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op);
    return {op, 26'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic ex(input logic [31:0] ir, input logic [31:0] rs, input logic [31:0] rt);
    IRE = ir;
    RSE = rs;
    RTE = rt;
    tick();
  endtask

  task automatic md_wait(input logic [31:0] ir, output int cyc);
    IRE = ir;
    cyc = 0;
    while (MdStall && cyc < 40) begin
      tick();
      chk("bubble", IRM | PC4M | AOM | RTM, 32'h0);
      cyc++;
    end
  endtask

  initial begin
    Reset = 0; IRE = 0; PC4E = 32'h100; RSE = 0; RTE = 0; EXTE = 0;
    Forward_RS_E_Sel = 0; Forward_RT_E_Sel = 0; MUX_RF_WD_OUT = 0;
    #2;
    chk("rst_aom", AOM, 0);
    chk("rst_irm", IRM | PC4M | RTM, 0);
    chk("rst_stall", {31'b0, MdStall}, 0);
    @(negedge Clk) Reset = 1;
    ex(rt_ins(FN_ADDU), 3, 4);
    chk("addu", AOM, 7);
    chk("addu_irm", IRM, rt_ins(FN_ADDU));
    chk("addu_pc4m", PC4M, 32'h100);
    chk("addu_rtm", RTM, 4);
    #2 Reset = 0;
    #1 chk("async_rst", IRM | PC4M | AOM | RTM, 0);
    @(negedge Clk) Reset = 1;
    // forwarding paths
    EXTE = 32'h10;
    ex(i_ins(OP_ORI), 0, 0);
    chk("ori", AOM, 32'h10);
    Forward_RS_E_Sel = 3'd1;
    ex(rt_ins(FN_SUBU), 32'hDEAD, 5);
    chk("fwd_aom_subu", AOM, 32'h0B);
    Forward_RS_E_Sel = 3'd2; MUX_RF_WD_OUT = 32'hFFFFFFFF;
    ex(rt_ins(FN_SLT), 0, 0);
    chk("fwd_wd_slt", AOM, 1);
    ex(rt_ins(FN_SLTU), 0, 0);
    chk("sltu", AOM, 0);
    Forward_RS_E_Sel = 3'd0; Forward_RT_E_Sel = 3'd1;
    ex(rt_ins(FN_ADDU), 5, 32'h99);
    chk("fwd_rt_aom", AOM, 5);
    chk("fwd_rt_rtm", RTM, 0);
    Forward_RT_E_Sel = 3'd0;
    EXTE = 32'h1234;
    ex(i_ins(OP_LUI), 0, 0);
    chk("lui", AOM, 32'h12340000);
    EXTE = 8;
    ex(i_ins(OP_LW), 32'hFFFFFFFC, 0);
    chk("lw_wrap", AOM, 4);
    ex(i_ins(OP_JAL), 0, 0);
    chk("jal", AOM, 32'h104);
    ex(rt_ins(FN_SLL, 5'd4), 0, 1);
    chk("sll", AOM, 32'h10);
    ex(i_ins(6'h3f), 1, 1);
    chk("other", AOM, 0);
    // signed mult then mflo
    IRE = rt_ins(FN_MULT); RSE = 32'hFFFFFFFE; RTE = 3;
    #1 chk("start_nostall", {31'b0, MdStall}, 0);
    tick();
    md_wait(rt_ins(FN_MFLO), n);
    chk("mult_busy", n, 5);
    tick();
    chk("mult_lo", AOM, 32'hFFFFFFFA);
    ex(rt_ins(FN_MFHI), 0, 0);
    chk("mult_hi", AOM, 32'hFFFFFFFF);
    ex(rt_ins(FN_MULTU), 32'hFFFFFFFE, 3);
    md_wait(rt_ins(FN_MFHI), n);
    chk("multu_busy", n, 5);
    tick();
    chk("multu_hi", AOM, 32'h2);
    ex(rt_ins(FN_MFLO), 0, 0);
    chk("multu_lo", AOM, 32'hFFFFFFFA);
    // signed divide, then unsigned divide by zero keeps HI/LO
    ex(rt_ins(FN_DIV), 32'hFFFFFFF9, 2);
    md_wait(rt_ins(FN_MFLO), n);
    chk("div_busy", n, 10);
    tick();
    chk("div_lo", AOM, 32'hFFFFFFFD);
    ex(rt_ins(FN_MFHI), 0, 0);
    chk("div_hi", AOM, 32'hFFFFFFFF);
    ex(rt_ins(FN_DIVU), 7, 0);
    md_wait(rt_ins(FN_MFLO), n);
    chk("div0_busy", n, 10);
    tick();
    chk("div0_lo", AOM, 32'hFFFFFFFD);
    ex(rt_ins(FN_MFHI), 0, 0);
    chk("div0_hi", AOM, 32'hFFFFFFFF);
    // non-md instruction overlaps a running mult, then reset abandons it
    ex(rt_ins(FN_MULT), 2, 3);
    IRE = rt_ins(FN_ADDU); RSE = 3; RTE = 4;
    #1 chk("overlap_nostall", {31'b0, MdStall}, 0);
    tick();
    chk("overlap_addu", AOM, 7);
    ex(32'h0, 0, 0);
    IRE = rt_ins(FN_MFLO);
    #1 chk("busy_stall", {31'b0, MdStall}, 1);
    #2 Reset = 0;
    #1 chk("rst_stall_clr", {31'b0, MdStall}, 0);
    @(negedge Clk) Reset = 1;
    repeat (6) ex(32'h0, 0, 0);
    ex(rt_ins(FN_MFLO), 0, 0);
    chk("rst_lo", AOM, 0);
    ex(rt_ins(FN_MFHI), 0, 0);
    chk("rst_hi", AOM, 0);
    // mthi/mtlo, mtlo held off while busy, back-to-back mult
    ex(rt_ins(FN_MTHI), 32'h1234, 0);
    ex(rt_ins(FN_MFHI), 0, 0);
    chk("mthi", AOM, 32'h1234);
    ex(rt_ins(FN_MULT), 2, 3);
    RSE = 32'h55;
    md_wait(rt_ins(FN_MTLO), n);
    chk("mtlo_busy", n, 5);
    tick();
    ex(rt_ins(FN_MFLO), 0, 0);
    chk("mtlo", AOM, 32'h55);
    ex(rt_ins(FN_MULT), 2, 3);
    RSE = 4; RTE = 5;
    md_wait(rt_ins(FN_MULT), n);
    chk("b2b_wait", n, 5);
    tick();
    md_wait(rt_ins(FN_MFLO), n);
    chk("b2b_busy", n, 5);
    tick();
    chk("b2b_lo", AOM, 20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
